// File: rtl/alu_issue_seq.sv
// Issue sequencer for LC-3b ADD/AND/NOT/SHF: drives a shared ALU, runs SHF bit-serially,
// and holds one result for a ready/valid consumer. Optional cc output: ALU_ISSUE_SEQ_CC_EN.
module alu_issue_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  input  logic [15:0] sr1_val,
  input  logic [15:0] sr2_val,
  output logic [3:0]  aluop,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_f,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [2:0]  dest,
  output logic        illegal,
  output logic [2:0]  cc
);

  // lc3b_aluop encoding shared with the datapath ALU
  localparam logic [3:0] alu_add  = 4'd0;
  localparam logic [3:0] alu_and  = 4'd1;
  localparam logic [3:0] alu_not  = 4'd2;
  localparam logic [3:0] alu_pass = 4'd3;

  localparam logic [3:0] op_add = 4'b0001;
  localparam logic [3:0] op_and = 4'b0101;
  localparam logic [3:0] op_not = 4'b1001;
  localparam logic [3:0] op_shf = 4'b1101;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [5:0]  ctl_q;      // instr[5:0]: immediate/register select, imm5, shift type
  logic [15:0] sr1_q, sr2_q;
  logic [15:0] work;
  logic [15:0] result_q;
  logic [3:0]  count;
  logic        accept;
  logic        capture;
  logic        in_is_shf;
  logic        in_legal;
  logic [15:0] imm_sext;
  logic [15:0] work_shifted;
  logic        unused_bits;

  assign unused_bits = ^instr[8:6];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign accept    = in_valid & in_ready;
  assign in_is_shf = (instr[15:12] == op_shf);
  assign in_legal  = (instr[15:12] == op_add) || (instr[15:12] == op_and) ||
                     (instr[15:12] == op_not) || in_is_shf;
  assign imm_sext  = {{11{ctl_q[4]}}, ctl_q[4:0]};

  // The shift path spends one extra SHIFT cycle with count at 0, latching the finished
  // word through the ALU pass path, so both paths write result_q the same way.
  assign capture = (state == EXEC) || ((state == SHIFT) && (count == 4'd0));

  always_comb begin
    unique case ({ctl_q[4], ctl_q[5]})
      2'b10:   work_shifted = {1'b0, work[15:1]};
      2'b11:   work_shifted = {work[15], work[15:1]};
      default: work_shifted = {work[14:0], 1'b0};
    endcase
  end

  // NOTE: every sequential register is written with <= so all state updates see
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_q     <= 4'd0;
      ctl_q    <= 6'd0;
      sr1_q    <= 16'd0;
      sr2_q    <= 16'd0;
      work     <= 16'd0;
      result_q <= 16'd0;
      count    <= 4'd0;
      dest     <= 3'd0;
      illegal  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= instr[15:12];
        ctl_q   <= instr[5:0];
        sr1_q   <= sr1_val;
        sr2_q   <= sr2_val;
        work    <= sr1_val;
        count   <= in_is_shf ? instr[3:0] : 4'd0;
        dest    <= instr[11:9];
        illegal <= ~in_legal;
      end
      if (capture) begin
        result_q <= alu_f;
      end else if (state == SHIFT) begin
        work  <= work_shifted;
        count <= count - 4'd1;
      end
    end
  end

  // NOTE: state_nxt and the ALU drive get defaults before the case so no path leaves
  // them unassigned, which would otherwise infer latches.
  always_comb begin
    state_nxt = state;
    aluop     = alu_pass;
    alu_a     = result_q;
    alu_b     = 16'd0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = (in_is_shf && (instr[3:0] != 4'd0)) ? SHIFT : EXEC;
      end
      EXEC: begin
        state_nxt = DONE;
        alu_a     = sr1_q;
        unique case (op_q)
          op_add: begin
            aluop = alu_add;
            alu_b = ctl_q[5] ? imm_sext : sr2_q;
          end
          op_and: begin
            aluop = alu_and;
            alu_b = ctl_q[5] ? imm_sext : sr2_q;
          end
          op_not:  aluop = alu_not;
          default: aluop = alu_pass;   // SHF by 0 and illegal opcodes forward sr1
        endcase
      end
      SHIFT: begin
        alu_a = work;
        if (count == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_ISSUE_SEQ_CC_EN
  logic [2:0] cc_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cc_q <= 3'b000;
    end else if (capture) begin
      if (alu_f[15])            cc_q <= 3'b100;
      else if (alu_f == 16'd0)  cc_q <= 3'b010;
      else                      cc_q <= 3'b001;
    end
  end

  assign cc = cc_q;
`else
  assign cc = 3'b000;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: vector table through the full handshake plus
// backpressure, out_ready-early, and reset corner sequences. Models the shared ALU.
module tb_alu_issue_seq;

  localparam logic [3:0] alu_add  = 4'd0;
  localparam logic [3:0] alu_and  = 4'd1;
  localparam logic [3:0] alu_not  = 4'd2;
  localparam logic [3:0] alu_pass = 4'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr, sr1_val, sr2_val;
  logic [3:0]  aluop;
  logic [15:0] alu_a, alu_b, alu_f;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [2:0]  dest;
  logic        illegal;
  logic [2:0]  cc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [15:0] res;
    logic [2:0]  dest;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  alu_issue_seq dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .sr1_val(sr1_val), .sr2_val(sr2_val), .aluop(aluop),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .dest(dest), .illegal(illegal), .cc(cc)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU seen by the sequencer
  always_comb begin
    case (aluop)
      alu_add:  alu_f = alu_a + alu_b;
      alu_and:  alu_f = alu_a & alu_b;
      alu_not:  alu_f = ~alu_a;
      alu_pass: alu_f = alu_a;
      default:  alu_f = 16'hDEAD;
    endcase
  end

  function automatic logic [2:0] exp_cc(input logic [15:0] r);
`ifdef ALU_ISSUE_SEQ_CC_EN
    if (r[15])          return 3'b100;
    else if (r == 0)    return 3'b010;
    else                return 3'b001;
`else
    return (r == 16'hFFFF && r == 16'h0000) ? 3'b111 : 3'b000;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Drive one bundle from IDLE and return edges until out_valid (40 on timeout).
  task automatic issue(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    instr    = i;
    sr1_val  = a;
    sr2_val  = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " in_ready after handshake"}, in_ready, 1'b1);
    check({tag, " out_valid after handshake"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{16'h1261, 16'h0005, 16'h0000, 16'h0006, 3'd1, 1'b0, 1};   // ADD imm
    vecs[1]  = '{16'h5442, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'd2, 1'b0, 1};   // AND reg
    vecs[2]  = '{16'h1261, 16'hFFFF, 16'h0000, 16'h0000, 3'd1, 1'b0, 1};   // ADD wrap
    vecs[3]  = '{16'h1042, 16'h7FFF, 16'h0001, 16'h8000, 3'd0, 1'b0, 1};   // ADD reg
    vecs[4]  = '{16'h16BF, 16'h0010, 16'h0000, 16'h000F, 3'd3, 1'b0, 1};   // ADD imm -1
    vecs[5]  = '{16'h5B2F, 16'h1234, 16'hFFFF, 16'h0004, 3'd5, 1'b0, 1};   // AND imm
    vecs[6]  = '{16'h9DFF, 16'h00FF, 16'h1111, 16'hFF00, 3'd6, 1'b0, 1};   // NOT
    vecs[7]  = '{16'hD234, 16'h8000, 16'h0000, 16'hF800, 3'd1, 1'b0, 5};   // SHF sra 4
    vecs[8]  = '{16'hDE03, 16'h8421, 16'h0000, 16'h2108, 3'd7, 1'b0, 4};   // SHF sll 3
    vecs[9]  = '{16'hD811, 16'h8001, 16'h0000, 16'h4000, 3'd4, 1'b0, 2};   // SHF srl 1
    vecs[10] = '{16'hD430, 16'hABCD, 16'h0000, 16'hABCD, 3'd2, 1'b0, 1};   // SHF by 0
    vecs[11] = '{16'hF025, 16'h1357, 16'h2468, 16'h1357, 3'd0, 1'b1, 1};   // illegal
    vecs[12] = '{16'hD03F, 16'h8000, 16'h0000, 16'hFFFF, 3'd0, 1'b0, 16};  // SHF sra 15
    vecs[13] = '{16'h0E05, 16'h00AA, 16'h0000, 16'h00AA, 3'd7, 1'b1, 1};   // illegal BR

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 16'h0; sr1_val = 16'h0; sr2_val = 16'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, 16'h0000);
    check("reset dest", dest, 3'd0);
    check("reset illegal", illegal, 1'b0);
    check("reset cc", cc, 3'b000);
    check("reset aluop", aluop, alu_pass);
    check("reset alu_a", alu_a, 16'h0000);
    check("reset alu_b", alu_b, 16'h0000);

    for (int v = 0; v < 14; v++) begin
      check($sformatf("v%0d in_ready before issue", v), in_ready, 1'b1);
      issue(vecs[v].instr, vecs[v].sr1, vecs[v].sr2, lat);
      check($sformatf("v%0d latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d result", v), result, vecs[v].res);
      check($sformatf("v%0d dest", v), dest, vecs[v].dest);
      check($sformatf("v%0d illegal", v), illegal, vecs[v].ill);
      check($sformatf("v%0d cc", v), cc, exp_cc(vecs[v].res));
      check($sformatf("v%0d in_ready busy", v), in_ready, 1'b0);
      release_out($sformatf("v%0d", v));
    end

    // Backpressure: result held for 10 cycles while a competing bundle is offered
    issue(16'h1261, 16'h0005, 16'h0000, lat);
    check("bp latency", lat, 1);
    in_valid = 1'b1; instr = 16'h9DFF; sr1_val = 16'h0F0F;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp c%0d out_valid", c), out_valid, 1'b1);
      check($sformatf("bp c%0d result", c), result, 16'h0006);
      check($sformatf("bp c%0d in_ready", c), in_ready, 1'b0);
    end
    check("bp dest held", dest, 3'd1);
    in_valid = 1'b0;
    release_out("bp");

    // out_ready held high while the shift runs must not end it early
    out_ready = 1'b1;
    issue(16'hDE02, 16'h0003, 16'h0000, lat);   // SHF sll 2 -> 0x000C, dest 7
    check("early out_ready latency", lat, 3);
    check("early out_ready result", result, 16'h000C);
    @(negedge clk);
    out_ready = 1'b0;
    check("early out_ready back to idle", in_ready, 1'b1);

    // Reset in the middle of a 15-step shift abandons it
    @(negedge clk);
    in_valid = 1'b1; instr = 16'hD03F; sr1_val = 16'h8000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid-shift busy", in_ready, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid-shift reset out_valid", out_valid, 1'b0);
    check("mid-shift reset in_ready", in_ready, 1'b1);
    check("mid-shift reset result", result, 16'h0000);
    check("mid-shift reset dest", dest, 3'd0);

    // Reset dominates an accept in the same cycle
    in_valid = 1'b1; instr = 16'h1261; sr1_val = 16'h0005;
    @(negedge clk);
    check("reset vs accept in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset vs accept no result", out_valid, 1'b0);
    check("reset vs accept result", result, 16'h0000);

    // Sequencer is usable after the abandoned operation
    issue(16'hF025, 16'h4321, 16'h0000, lat);
    check("post-reset illegal latency", lat, 1);
    check("post-reset illegal result", result, 16'h4321);
    check("post-reset illegal flag", illegal, 1'b1);
    release_out("post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
